// File: rtl/vga_pkg.sv
// Shared VGA timing constants, test-bar colours and counter-width helper.
package vga_pkg;

    typedef enum logic {StIdle, StRun} vga_state_e;

    // 800x600@60 (defaults)
    localparam int unsigned SVGA_H_DISPLAY = 800;
    localparam int unsigned SVGA_H_FP      = 40;
    localparam int unsigned SVGA_H_SYNC    = 128;
    localparam int unsigned SVGA_H_BP      = 88;
    localparam int unsigned SVGA_V_DISPLAY = 600;
    localparam int unsigned SVGA_V_FP      = 1;
    localparam int unsigned SVGA_V_SYNC    = 4;
    localparam int unsigned SVGA_V_BP      = 23;

    // 640x480@60
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    // Bar colours as {r, g, b} on/off flags
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic int unsigned vga_cnt_width(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

    function automatic logic [2:0] vga_bar_rgb(input int unsigned idx);
        case (idx)
            0:       return BAR_WHITE;
            1:       return BAR_YELLOW;
            2:       return BAR_CYAN;
            3:       return BAR_GREEN;
            4:       return BAR_MAGENTA;
            5:       return BAR_RED;
            6:       return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous clear; DEPTH = 0 is a plain wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator with run/idle control and pipelined pixel output stage.
// Build macro VGA_TEST_PATTERN_EN adds test_mode_i and an internal 8-bar colour generator.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = SVGA_H_DISPLAY,
    parameter int unsigned H_FP      = SVGA_H_FP,
    parameter int unsigned H_SYNC    = SVGA_H_SYNC,
    parameter int unsigned H_BP      = SVGA_H_BP,
    parameter int unsigned V_DISPLAY = SVGA_V_DISPLAY,
    parameter int unsigned V_FP      = SVGA_V_FP,
    parameter int unsigned V_SYNC    = SVGA_V_SYNC,
    parameter int unsigned V_BP      = SVGA_V_BP,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned PIPE_LAT  = 0,
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W      = vga_cnt_width(H_TOTAL),
    localparam int unsigned Y_W      = vga_cnt_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode_i,
`endif
    input  logic [COLOR_W-1:0] in_r_i,
    input  logic [COLOR_W-1:0] in_g_i,
    input  logic [COLOR_W-1:0] in_b_i,
    output logic [X_W-1:0]     pixel_x_o,
    output logic [Y_W-1:0]     pixel_y_o,
    output logic               pixel_valid_o,
    output logic               frame_start_o,
    output logic               line_start_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               video_on_o,
    output logic [15:0]        frame_count_o
);

    // One extra bit so the sync end bound never aliases to 0 when H_BP or V_BP is 0.
    localparam logic [X_W:0] H_LAST = (X_W+1)'(H_TOTAL - 1);
    localparam logic [X_W:0] H_DISP = (X_W+1)'(H_DISPLAY);
    localparam logic [X_W:0] HS_BEG = (X_W+1)'(H_DISPLAY + H_FP);
    localparam logic [X_W:0] HS_END = (X_W+1)'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [Y_W:0] V_LAST = (Y_W+1)'(V_TOTAL - 1);
    localparam logic [Y_W:0] V_DISP = (Y_W+1)'(V_DISPLAY);
    localparam logic [Y_W:0] VS_BEG = (Y_W+1)'(V_DISPLAY + V_FP);
    localparam logic [Y_W:0] VS_END = (Y_W+1)'(V_DISPLAY + V_FP + V_SYNC);

    vga_state_e     state_q, state_d;
    logic [X_W-1:0] h_q, h_d;
    logic [Y_W-1:0] v_q, v_d;
    logic [15:0]    fc_q, fc_d;

    logic [X_W:0] h_ext;
    logic [Y_W:0] v_ext;
    logic         run, h_last, v_last;
    logic         valid0, hs0, vs0;

    assign h_ext  = {1'b0, h_q};
    assign v_ext  = {1'b0, v_q};
    assign run    = (state_q == StRun);
    assign h_last = (h_ext == H_LAST);
    assign v_last = (v_ext == V_LAST);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        fc_d    = fc_q;
        case (state_q)
            StIdle: begin
                if (en_i) state_d = StRun;
            end
            StRun: begin
                if (h_last) begin
                    h_d = '0;
                    if (v_last) begin
                        v_d  = '0;
                        fc_d = fc_q + 16'd1;
                        // Stop is only honoured here, so a frame is never cut short.
                        if (!en_i) state_d = StIdle;
                    end else begin
                        v_d = v_q + Y_W'(1);
                    end
                end else begin
                    h_d = h_q + X_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fc_q    <= fc_d;
        end
    end

    assign valid0 = run && (h_ext < H_DISP) && (v_ext < V_DISP);
    assign hs0    = run && (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs0    = run && (v_ext >= VS_BEG) && (v_ext < VS_END);

    assign pixel_x_o     = valid0 ? h_q : '1;
    assign pixel_y_o     = valid0 ? v_q : '1;
    assign pixel_valid_o = valid0;
    assign frame_start_o = run && (h_q == '0) && (v_q == '0);
    assign line_start_o  = run && (h_q == '0) && (v_ext < V_DISP);
    assign frame_count_o = fc_q;

    logic hs_dl, vs_dl, valid_dl;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DL_W  = X_W + 3;
    localparam int unsigned BAR_W = (H_DISPLAY >= 8) ? (H_DISPLAY / 8) : 1;
    logic [X_W-1:0] x_dl;
    logic [X_W-1:0] bar_idx;
    logic [2:0]     bar_rgb;
`else
    localparam int unsigned DL_W = 3;
`endif

    logic [DL_W-1:0] dl_in, dl_out;

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {pixel_x_o, hs0, vs0, valid0};
    assign {x_dl, hs_dl, vs_dl, valid_dl} = dl_out;
    assign bar_idx = x_dl / X_W'(BAR_W);
    assign bar_rgb = vga_bar_rgb(32'(bar_idx));
`else
    assign dl_in = {hs0, vs0, valid0};
    assign {hs_dl, vs_dl, valid_dl} = dl_out;
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (dl_in),
        .q_o     (dl_out)
    );

    logic               hsync_q, hsync_d, vsync_q, vsync_d, von_q, von_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

    always_comb begin
        src_r = in_r_i;
        src_g = in_g_i;
        src_b = in_b_i;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode_i) begin
            src_r = {COLOR_W{bar_rgb[2]}};
            src_g = {COLOR_W{bar_rgb[1]}};
            src_b = {COLOR_W{bar_rgb[0]}};
        end
`endif
        hsync_d = hs_dl ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = vs_dl ? VSYNC_POL : ~VSYNC_POL;
        von_d   = valid_dl;
        red_d   = valid_dl ? src_r : '0;
        green_d = valid_dl ? src_g : '0;
        blue_d  = valid_dl ? src_b : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            von_q   <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;
    assign video_on_o = von_q;
    assign red_o      = red_q;
    assign green_o    = green_q;
    assign blue_o     = blue_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomized self-checking bench for vga_timing_core on a reduced raster with a frame-level model.
module tb_vga_timing_core;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8, VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CW = 4;
    localparam int LAT = 2;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int XONES = (1 << XW) - 1;
    localparam int YONES = (1 << YW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          tm;
    logic [CW-1:0] in_r, in_g, in_b;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_valid, frame_start, line_start;
    logic          hsync, vsync, video_on;
    logic [CW-1:0] red, green, blue;
    logic [15:0]   frame_count;

    vga_timing_core #(
        .H_DISPLAY (HD), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_DISPLAY (VD), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (HP), .VSYNC_POL (VP), .COLOR_W (CW), .PIPE_LAT (LAT)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en_i          (en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode_i   (tm),
`endif
        .in_r_i        (in_r),
        .in_g_i        (in_g),
        .in_b_i        (in_b),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y),
        .pixel_valid_o (pixel_valid),
        .frame_start_o (frame_start),
        .line_start_o  (line_start),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .red_o         (red),
        .green_o       (green),
        .blue_o        (blue),
        .video_on_o    (video_on),
        .frame_count_o (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hs;
        bit vs;
        bit valid;
        int x;
    } req_t;

    int   tests_run = 0;
    int   tests_failed = 0;
    bit   m_run;
    int   m_pos;
    int   m_frames;
    req_t pq[$];
    bit   e_hs, e_vs, e_von;
    int   e_r, e_g, e_b;
    logic [2:0] bars [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_frames = 0;
        pq.delete();
        for (int i = 0; i < LAT; i++) pq.push_back('{hs: 1'b0, vs: 1'b0, valid: 1'b0, x: 0});
        e_hs = 1'b0; e_vs = 1'b0; e_von = 1'b0;
        e_r = 0; e_g = 0; e_b = 0;
    endtask

    function automatic req_t cur_req();
        req_t r;
        int h = m_pos % HT;
        int v = m_pos / HT;
        r.valid = m_run && h < HD && v < VD;
        r.hs    = m_run && h >= HD + HF && h < HD + HF + HS;
        r.vs    = m_run && v >= VD + VF && v < VD + VF + VS;
        r.x     = h;
        return r;
    endfunction

    task automatic check_outputs();
        req_t r = cur_req();
        int   h = m_pos % HT;
        int   v = m_pos / HT;
        chk("pixel_valid", 32'(pixel_valid), 32'(r.valid));
        chk("pixel_x", 32'(pixel_x), r.valid ? h : XONES);
        chk("pixel_y", 32'(pixel_y), r.valid ? v : YONES);
        chk("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
        chk("line_start", 32'(line_start), 32'(m_run && h == 0 && v < VD));
        chk("hsync", 32'(hsync), e_hs ? 32'(HP) : 32'(!HP));
        chk("vsync", 32'(vsync), e_vs ? 32'(VP) : 32'(!VP));
        chk("video_on", 32'(video_on), 32'(e_von));
        chk("red", 32'(red), e_r);
        chk("green", 32'(green), e_g);
        chk("blue", 32'(blue), e_b);
        chk("frame_count", 32'(frame_count), m_frames & 32'hFFFF);
    endtask

    // One pixel clock: check at negedge, drive, then advance the model on posedge.
    task automatic cycle(input bit en_v, input bit tm_v);
        req_t cur, old;
        int   br;
        @(negedge clk);
        check_outputs();
        en = en_v;
        tm = tm_v;
        in_r = CW'($urandom);
        in_g = CW'($urandom);
        in_b = CW'($urandom);
        cur = cur_req();
        pq.push_back(cur);
        old = pq.pop_front();
        @(posedge clk);
        e_hs  = old.hs;
        e_vs  = old.vs;
        e_von = old.valid;
        e_r = 0; e_g = 0; e_b = 0;
        if (old.valid) begin
            e_r = int'(in_r); e_g = int'(in_g); e_b = int'(in_b);
`ifdef VGA_TEST_PATTERN_EN
            if (tm_v) begin
                br = old.x / (HD / 8);
                e_r = bars[br][2] ? (1 << CW) - 1 : 0;
                e_g = bars[br][1] ? (1 << CW) - 1 : 0;
                e_b = bars[br][0] ? (1 << CW) - 1 : 0;
            end
`endif
        end
        if (!m_run) begin
            if (en_v) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_frames++;
            m_pos = 0;
            if (!en_v) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    initial begin
        bars[0] = 3'b111; bars[1] = 3'b110; bars[2] = 3'b011; bars[3] = 3'b010;
        bars[4] = 3'b101; bars[5] = 3'b100; bars[6] = 3'b001; bars[7] = 3'b000;
        reset_n = 1'b0;
        en = 1'b0;
        tm = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Idle with en low: blank, syncs inactive, coordinates all-ones
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0);

        // Continuous run across two full frames
        for (int i = 0; i < 2 * FRAME + 50; i++) cycle(1'b1, 1'b0);

        // Random enable, exercising stops, cancelled stops and restarts
        for (int i = 0; i < 1200; i++) cycle($urandom_range(0, 3) != 0, 1'b0);

        // Drop en mid-frame and hold it low: frame completes, then idle
        for (int i = 0; i < 2 * FRAME && !(m_run && m_pos == FRAME / 2); i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < FRAME + 30; i++) cycle(1'b0, 1'b0);

`ifdef VGA_TEST_PATTERN_EN
        for (int i = 0; i < FRAME + 10; i++) cycle(1'b1, 1'b1);
`endif

        // Asynchronous reset mid-line
        for (int i = 0; i < FRAME + 7; i++) cycle(1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
